// File: rtl/mem_access_unit.sv
// Load/store front end between the core memory stage and a word-wide block RAM port.
// One request in flight at a time; sub-word stores are done as read-modify-write.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    // WR_ACK and RESP both present a response; WR_ACK is reached only by word stores.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_ACK  = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [15:0] wdata_reg;
    logic [31:0] merge_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] shifted;
    logic [3:0]  byte_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic        ram_en_raw;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign ram_rst    = rst;
    // A RAM access is never issued while reset is asserted.
    assign ram_en     = ram_en_raw & ~rst;

    // Misalignment / range check on the live request, used only in the accept cycle.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = (req_addr[1:0] != 2'b00);
            2'd3:    req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr >= ADDR_LIMIT) begin
            req_err = 1'b1;
        end
    end

    // Load alignment and sign/zero extension of the returned RAM word.
    always_comb begin
        shifted = ram_dout >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            2'd0:    load_data = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
            default: load_data = ram_dout;
        endcase
    end

    // Byte-enable mask and replicated store data for sub-word merges.
    always_comb begin
        if (size_reg == 2'd0) begin
            byte_mask = 4'b0001 << addr_reg[1:0];
            lane_data = {4{wdata_reg[7:0]}};
        end else begin
            byte_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_reg[15:0]}};
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = byte_mask[gi] ? lane_data[gi*8 +: 8] : ram_dout[gi*8 +: 8];
        end
    endgenerate

    // RAM port: accept-cycle read/word write straight from the request, merged write in RMW_WR.
    always_comb begin
        ram_en_raw = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = 32'd0;
        ram_di     = 32'd0;
        if (state_reg == IDLE && req_valid && !req_err) begin
            ram_en_raw = 1'b1;
            ram_we     = req_we && (req_size == 2'd2);
            ram_addr   = {req_addr[31:2], 2'b00};
            ram_di     = req_wdata;
        end else if (state_reg == RMW_WR) begin
            ram_en_raw = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = {addr_reg[31:2], 2'b00};
            ram_di     = merge_reg;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'd0;
            size_reg       <= 2'd0;
            signed_reg     <= 1'b0;
            wdata_reg      <= 16'd0;
            merge_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= req_addr;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        wdata_reg  <= req_wdata[15:0];
                        if (req_err) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                            resp_err_reg   <= 1'b1;
                        end else if (!req_we) begin
                            state_reg <= RD_WAIT;
                        end else if (req_size == 2'd2) begin
                            state_reg      <= WR_ACK;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                            resp_err_reg   <= 1'b0;
                        end else begin
                            state_reg <= RMW_RD;
                        end
                    end
                end
                RD_WAIT: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= load_data;
                    resp_err_reg   <= 1'b0;
                end
                RMW_RD: begin
                    merge_reg <= merged;
                    state_reg <= RMW_WR;
                end
                RMW_WR: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= 32'd0;
                    resp_err_reg   <= 1'b0;
                end
                WR_ACK, RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= 32'd0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small behavioural block RAM.
module tb_mem_access_unit;

    localparam logic [31:0] ADDR_LIMIT = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic        ram_we;
    logic        ram_rst;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int wr_cnt   = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_rst    (ram_rst),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_dout   (ram_dout)
    );

    // Behavioural RAM: one-cycle read latency, whole-word writes.
    always @(posedge clk) begin
        if (ram_rst) begin
            ram_dout <= 32'd0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr[11:2]] <= ram_di;
            else        ram_dout <= mem[ram_addr[11:2]];
        end
    end

    // Count RAM accesses and writes.
    always @(posedge clk) begin
        if (ram_en) en_cnt <= en_cnt + 1;
        if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request with resp_ready=1 and check timing, data and RAM activity.
    task automatic txn(input string name, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int lat;
        int en0;
        int exp_en;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        check({name, " acc_en"}, {31'd0, ram_en}, {31'd0, !exp_err});
        check({name, " acc_we"}, {31'd0, ram_we}, {31'd0, we && size == 2'd2 && !exp_err});
        if (!exp_err) check({name, " acc_addr"}, ram_addr, {addr[31:2], 2'b00});
        en0 = en_cnt;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        @(negedge clk);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        check({name, " latency"}, lat, exp_lat);
        check({name, " rdata"}, rd, exp_rdata);
        check({name, " err"}, {31'd0, er}, {31'd0, exp_err});
        @(negedge clk);
        check({name, " resp_drop"}, {31'd0, resp_valid}, 32'd0);
        check({name, " ready_back"}, {31'd0, req_ready}, 32'd1);
        exp_en = exp_err ? 0 : (exp_lat == 3 ? 2 : 1);
        check({name, " ram_accesses"}, en_cnt - en0, exp_en);
        $display("txn %-12s we=%0d size=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 name, we, size, addr, wdata, rd, er, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int          en0;
        int          w0;
        int          lat;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ram_rst", {31'd0, ram_rst}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", {31'd0, resp_err}, 32'd0);
        check("rst ram_en", {31'd0, ram_en}, 32'd0);
        check("rst ram_we", {31'd0, ram_we}, 32'd0);
        check("rst ram_addr", ram_addr, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        $display("txn reset done");

        // Word store/load and sub-word read-modify-write.
        txn("sw100",  1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, 32'h0, 1'b0, 1);
        txn("lw100",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1122_3344, 1'b0, 2);
        txn("sb101",  1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 32'h0, 1'b0, 3);
        txn("lw100b", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1122_AB44, 1'b0, 2);
        txn("sh102",  1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 1'b0, 3);
        txn("lw100c", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hBEEF_AB44, 1'b0, 2);
        txn("lb103",  1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFF_FFBE, 1'b0, 2);
        txn("lbu101", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0000_00AB, 1'b0, 2);
        txn("lhu102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h0000_BEEF, 1'b0, 2);
        txn("lh100",  1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'hFFFF_AB44, 1'b0, 2);

        // Sign/zero extension.
        txn("sw200",  1'b1, 2'd2, 1'b0, 32'h200, 32'h0000_8080, 32'h0, 1'b0, 1);
        txn("lb200",  1'b0, 2'd0, 1'b1, 32'h200, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        txn("lbu200", 1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 32'h0000_0080, 1'b0, 2);
        txn("lh200",  1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 32'hFFFF_8080, 1'b0, 2);
        txn("lhu202", 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h0000_0000, 1'b0, 2);
        txn("lb201",  1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 32'hFFFF_FF80, 1'b0, 2);

        // Last legal word, then error cases.
        txn("sw_top", 1'b1, 2'd2, 1'b0, ADDR_LIMIT - 32'd4, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
        txn("lw_top", 1'b0, 2'd2, 1'b0, ADDR_LIMIT - 32'd4, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
        txn("e_lh103", 1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'h0, 1'b1, 1);
        txn("e_sw102", 1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        txn("e_lwlim", 1'b0, 2'd2, 1'b0, ADDR_LIMIT, 32'h0, 32'h0, 1'b1, 1);
        txn("e_size3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        txn("e_sh101", 1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 32'h0, 1'b1, 1);
        txn("lw_intact", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hBEEF_AB44, 1'b0, 2);

        // Back-pressure: response held stable while resp_ready=0.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h100; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        held = resp_rdata;
        check("bp rdata", held, 32'hBEEF_AB44);
        en0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp rdata_hold", resp_rdata, 32'hBEEF_AB44);
            check("bp req_ready", {31'd0, req_ready}, 32'd0);
            check("bp ram_en", {31'd0, ram_en}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp consumed", {31'd0, resp_valid}, 32'd0);
        check("bp ready_back", {31'd0, req_ready}, 32'd1);
        check("bp no_access", en_cnt - en0, 32'd0);
        $display("txn backpressure lw100 rdata=0x%08h held 5 cycles", held);

        // Reset during RMW_RD of a byte store; a request during reset must not reach RAM.
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h100; req_wdata = 32'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'hDEAD_BEEF;
        #1;
        check("rr ram_en_in_rst", {31'd0, ram_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rr resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rr req_ready", {31'd0, req_ready}, 32'd1);
        check("rr no_write", wr_cnt - w0, 32'd0);
        $display("txn reset_abort sb100 0xFF aborted in RMW_RD");
        txn("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hBEEF_AB44, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
